// File: rtl/fp_mc_sched.sv
// Sequencer for the shared iterative FDIV.S/FSQRT.S unit: accepts one op from EX,
// counts its latency, requests the FP writeback port and stalls dependent ID instructions.
module fp_mc_sched #(
    parameter int DIV_CYCLES  = 14,
    parameter int SQRT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_ex,
    input  logic [6:0] opcode_ex,
    input  logic [6:0] funct7_ex,
    input  logic [4:0] rd_ex,
    input  logic       flush_ex,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_id,
    input  logic       fp_use_id,
    input  logic       mc_id,
    input  logic       wb_gnt,
    output logic       mc_start,
    output logic       mc_op,
    output logic       wb_req,
    output logic [4:0] wb_rd,
    output logic       stall_o,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT_WB = 2'd2
    } state_t;

    localparam logic [6:0] OP_FP    = 7'b1010011;
    localparam logic [6:0] F7_FDIV  = 7'b0001100;
    localparam logic [6:0] F7_FSQRT = 7'b0101100;
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);
    localparam logic [4:0] SQRT_LOAD = 5'(SQRT_CYCLES - 1);

    function automatic logic is_mc_op(input logic [6:0] opc, input logic [6:0] f7);
        return (opc == OP_FP) && ((f7 == F7_FDIV) || (f7 == F7_FSQRT));
    endfunction

    function automatic logic reg_hit(input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] rd, input logic [4:0] tgt);
        return (r1 == tgt) || (r2 == tgt) || (rd == tgt);
    endfunction

    state_t     state_r, state_nx_s;
    logic [4:0] cnt_r, cnt_nx_s;
    logic [4:0] rd_p_r;
    logic       op_p_r;
    logic       mc_start_r, busy_r, wb_req_r;
    logic [4:0] wb_rd_r;
    logic       accept_s, sqrt_ex_s;

    assign sqrt_ex_s = (funct7_ex == F7_FSQRT);
    assign accept_s  = (state_r == IDLE) && valid_ex && is_mc_op(opcode_ex, funct7_ex) && !flush_ex;

    // Next-state and latency counter; the counter saturates at zero and reloads only on accept.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = RUN;
                    cnt_nx_s   = sqrt_ex_s ? SQRT_LOAD : DIV_LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 5'd0) begin
                    state_nx_s = WAIT_WB;
                end else begin
                    cnt_nx_s = cnt_r - 5'd1;
                end
            end
            WAIT_WB: begin
                if (wb_gnt) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_WB;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 5'd0;
            end
        endcase
    end

    // State, pending-op capture and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 5'd0;
            rd_p_r     <= 5'd0;
            op_p_r     <= 1'b0;
            mc_start_r <= 1'b0;
            busy_r     <= 1'b0;
            wb_req_r   <= 1'b0;
            wb_rd_r    <= 5'd0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            mc_start_r <= accept_s;
            busy_r     <= (state_nx_s != IDLE);
            wb_req_r   <= (state_nx_s == WAIT_WB);
            wb_rd_r    <= (state_nx_s == WAIT_WB) ? rd_p_r : 5'd0;
            if (accept_s) begin
                rd_p_r <= rd_ex;
                op_p_r <= sqrt_ex_s;
            end
        end
    end

    // Hazard terms: pending destination (RAW/WAW), unit occupancy, and the op entering this cycle.
    assign stall_o = (busy_r && fp_use_id && reg_hit(rs1_id, rs2_id, rd_id, rd_p_r))
                   || (busy_r && mc_id)
                   || (accept_s && fp_use_id && reg_hit(rs1_id, rs2_id, rd_id, rd_ex));

    assign mc_start = mc_start_r;
    assign mc_op    = op_p_r;
    assign wb_req   = wb_req_r;
    assign wb_rd    = wb_rd_r;
    assign busy     = busy_r;

endmodule
